// File: rtl/gate_truth_checker.sv
// gate_truth_checker: walks every input vector of a small gate under test,
// holds each vector for SETTLE+1 cycles, samples the gate output in the last
// cycle and compares it against the selected AND/OR/NAND/NOR function.
// Reports pass/fail, the mismatch count and the first failing vector.
module gate_truth_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      func_sel,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_vec,
  output logic            first_fail_valid
);

  // settle counter only ever holds SETTLE-1 down to 0
  localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_INIT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    func_q;
  logic          expected;
  logic          mismatch;
  logic [N_IN:0] err_next;

  // reference response of the selected gate function for the current vector
  always_comb begin
    case (func_q)
      2'b00:   expected = &stim;
      2'b01:   expected = |stim;
      2'b10:   expected = ~&stim;
      default: expected = ~|stim;
    endcase
  end

  // case-inequality so an undriven/unknown gate output is flagged in sim
  assign mismatch = (dut_out !== expected);
  assign err_next = err_count + {{N_IN{1'b0}}, mismatch};

  // sequencer: IDLE -> (SETTLE -> SAMPLE) per vector -> DONE -> IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      cnt              <= '0;
      func_q           <= 2'b00;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            func_q           <= func_sel;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            stim             <= '0;
            cnt              <= CNT_INIT;
            busy             <= 1'b1;
            state            <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end
        S_SAMPLE: begin
          err_count <= err_next;
          if (mismatch && !first_fail_valid) begin
            first_fail_vec   <= stim;
            first_fail_valid <= 1'b1;
          end
          if (&stim) begin
            // last vector: publish the verdict including this sample
            done  <= 1'b1;
            pass  <= (err_next == '0);
            stim  <= '0;
            state <= S_DONE;
          end else begin
            stim  <= stim + 1'b1;
            cnt   <= CNT_INIT;
            state <= S_SETTLE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: a behavioural gate (ideal with
// latency, stuck-at, or per-vector fault mask) feeds the checker; a run-level
// reference model pushes the expected verdict, the monitor pops it on done.
module tb_gate_truth_checker;
  localparam int N  = 3;
  localparam int S  = 4;
  localparam int NV = 1 << N;
  localparam int RUN = NV * (S + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    func_sel = 2'b00;
  logic          dut_out;
  logic [N-1:0]  stim;
  logic          busy, done, pass, first_fail_valid;
  logic [N:0]    err_count;
  logic [N-1:0]  first_fail_vec;

  gate_truth_checker #(.N_IN(N), .SETTLE(S)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func_sel(func_sel),
    .dut_out(dut_out), .stim(stim), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int err;
    int ffv;
    bit ffvalid;
    bit pass;
    int done_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // gate truth functions straight from their definitions on integers
  function automatic logic ref_f(input logic [1:0] f, input int v);
    case (f)
      2'b00:   return v == NV - 1;
      2'b01:   return v != 0;
      2'b10:   return v != NV - 1;
      default: return v == 0;
    endcase
  endfunction

  // behavioural gate under test
  int            g_mode = 0;   // 0 ideal w/ latency, 1 stuck-at, 2 fault mask
  int            g_lat  = 0;
  logic          g_stuck = 1'b0;
  logic [1:0]    g_func = 2'b00;
  logic [NV-1:0] g_mask = '0;
  logic [N-1:0]  hist [0:7];

  initial for (int k = 0; k < 8; k++) hist[k] = '0;
  always @(posedge clk) begin
    hist[0] <= stim;
    for (int k = 1; k < 8; k++) hist[k] <= hist[k-1];
  end

  always_comb begin
    dut_out = 1'b0;
    case (g_mode)
      0: dut_out = ref_f(g_func, (g_lat == 0) ? int'(stim) : int'(hist[g_lat-1]));
      1: dut_out = g_stuck;
      default: dut_out = ref_f(g_func, int'(stim)) ^ g_mask[stim];
    endcase
  end

  // run-level reference: what each vector's sample sees, then tally
  function automatic exp_t model(input logic [1:0] f, input int mode, input int lat,
                                 input logic stuck, input logic [NV-1:0] mask,
                                 input int dcyc);
    exp_t e;
    e.err = 0; e.ffv = 0; e.ffvalid = 0;
    for (int v = 0; v < NV; v++) begin
      int   src;
      logic got;
      // a vector is held S+1 cycles; a slower gate still shows the previous one
      src = (lat <= S) ? v : ((v == 0) ? 0 : v - 1);
      case (mode)
        0:       got = ref_f(f, src);
        1:       got = stuck;
        default: got = ref_f(f, v) ^ mask[v];
      endcase
      if (got != ref_f(f, v)) begin
        if (!e.ffvalid) begin e.ffvalid = 1; e.ffv = v; end
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    e.done_cyc = dcyc;
    return e;
  endfunction

  // monitor: every done pulse must match the oldest expected run
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("err_count", err_count, e.err);
        chk("first_fail_valid", first_fail_valid, e.ffvalid);
        if (e.ffvalid) chk("first_fail_vec", first_fail_vec, e.ffv);
        chk("pass", pass, e.pass);
        chk("done_cycle", cyc, e.done_cyc);
      end
    end
  end

  task automatic setup_gate(input logic [1:0] f, input int mode, input int lat,
                            input logic stuck, input logic [NV-1:0] mask);
    g_func = f; g_mode = mode; g_lat = lat; g_stuck = stuck; g_mask = mask;
  endtask

  task automatic run_one(input logic [1:0] f, input int mode, input int lat,
                         input logic stuck, input logic [NV-1:0] mask, input bit poke);
    bit busy_bad;
    @(negedge clk);
    setup_gate(f, mode, lat, stuck, mask);
    func_sel = f;
    start = 1'b1;
    sb.push_back(model(f, mode, lat, stuck, mask, cyc + 1 + RUN));
    @(negedge clk);
    start = 1'b0;
    busy_bad = 0;
    for (int t = 0; t < 4 * RUN && sb.size() != 0; t++) begin
      if (!busy) busy_bad = 1;
      if (poke && t == 13) begin func_sel = ~f; start = 1'b1; end
      if (poke && t == 14) start = 1'b0;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL run_timeout: got no done expected done by cycle %0d", sb[0].done_cyc);
      sb.delete();
    end
    chk("busy_held_during_run", busy_bad, 0);
    func_sel = f;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_stim"}, stim, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_first_fail_vec"}, first_fail_vec, 0);
    chk({tag, "_first_fail_valid"}, first_fail_valid, 0);
  endtask

  initial begin
    bit seen;
    #3 rst_n = 1'b0;
    #20;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // ideal AND, stuck-0 OR, pipelined AND at the latency boundary
    run_one(2'b00, 0, 0, 1'b0, '0, 0);
    run_one(2'b01, 1, 0, 1'b0, '0, 0);
    run_one(2'b00, 0, 4, 1'b0, '0, 0);
    run_one(2'b00, 0, 5, 1'b0, '0, 0);
    // every vector wrong: count reaches 2^N without wrapping
    run_one(2'b11, 2, 0, 1'b0, '1, 0);
    // NAND run with func_sel change and start pulse mid-run
    run_one(2'b10, 0, 0, 1'b0, '0, 1);

    // reset in the middle of a stuck-0 OR run
    @(negedge clk);
    setup_gate(2'b01, 1, 0, 1'b0, '0);
    func_sel = 2'b01;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("err_before_reset", err_count, 2);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("idle_after_reset_busy", busy, 0);
    run_one(2'b00, 0, 0, 1'b0, '0, 0);

    // start held high: back-to-back runs with stuck-1 AND
    @(negedge clk);
    setup_gate(2'b00, 1, 0, 1'b1, '0);
    func_sel = 2'b00;
    sb.push_back(model(2'b00, 1, 0, 1'b1, '0, cyc + 1 + RUN));
    sb.push_back(model(2'b00, 1, 0, 1'b1, '0, cyc + 1 + RUN + 2 + RUN));
    start = 1'b1;
    seen = 0;
    for (int t = 0; t < 4 * RUN && !seen; t++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("held_first_done_seen", seen, 1);
    @(negedge clk);
    chk("held_idle_busy", busy, 0);
    chk("held_idle_err_kept", err_count, 7);
    @(negedge clk);
    chk("held_restart_busy", busy, 1);
    chk("held_restart_err_clear", err_count, 0);
    start = 1'b0;
    for (int t = 0; t < 4 * RUN && sb.size() != 0; t++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL held_timeout: got %0d pending runs expected 0", sb.size());
      sb.delete();
    end

    // randomized runs
    for (int r = 0; r < 20; r++) begin
      logic [1:0]    f;
      int            m, l;
      logic          s;
      logic [NV-1:0] mk;
      f  = 2'($urandom_range(0, 3));
      m  = $urandom_range(0, 2);
      l  = $urandom_range(0, 6);
      s  = 1'($urandom_range(0, 1));
      mk = NV'($urandom);
      run_one(f, m, l, s, mk, 0);
    end

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_truth_checker.md
Name: gate_truth_checker

Overview:
- Exhaustive truth-table sequencer and response checker for small combinational gate models (2/3-input AND/OR family).
- Drives every input vector to a gate under test, waits a programmable settle time, and samples the gate output.
- Compares the sample against the expected function and reports pass/fail, the error count, and the first failing vector.
- Acts as the receive/check end of the gate stimulus interface, replacing hand-written per-vector delay lists with a clocked, self-checking engine.

Parameters:
- N_IN, 3, number of gate inputs driven; legal range 1..8.
- SETTLE, 4, cycles each vector is held before sampling; must be >= 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  starts a run; sampled in IDLE only.
- func_sel  in  2  expected function: 00 AND, 01 OR, 10 NAND, 11 NOR; latched at start.
- dut_out  in  1  output of the gate under test.
- stim  out  N_IN  input vector driven to the gate under test.
- busy  out  1  high from start acceptance until DONE exits.
- done  out  1  one-cycle pulse when a run completes.
- pass  out  1  1 if the last run had zero mismatches; held until the next start.
- err_count  out  N_IN+1  mismatch count of the last/current run.
- first_fail_vec  out  N_IN  first mismatching vector.
- first_fail_valid  out  1  first_fail_vec is meaningful.

Behaviour:
- Reset (async, immediate): state=IDLE; stim=0; busy=0; done=0; pass=0; err_count=0; first_fail_vec=0; first_fail_valid=0; settle counter=0; latched func=AND.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE, start=1 at an edge:
  - Latch func_sel.
  - Clear err_count, first_fail_valid, pass.
  - stim<=0; cnt<=SETTLE-1; busy<=1; go to SETTLE.
- SETTLE: if cnt==0 go to SAMPLE, else cnt--. SETTLE occupies exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - Compute expected from stim and the latched func: AND=&stim, OR=|stim, NAND=~&stim, NOR=~|stim.
  - Mismatch when dut_out != expected. In simulation, X/Z on dut_out counts as a mismatch (case-inequality).
  - On mismatch: err_count++. If first_fail_valid==0, capture first_fail_vec=stim and set first_fail_valid=1.
  - If stim == all-ones: go to DONE.
  - Otherwise: stim<=stim+1; cnt<=SETTLE-1; go to SETTLE.
- Each vector is held SETTLE+1 cycles and sampled in its last cycle. A DUT with latency <= SETTLE cycles passes.
- Run length: 2^N_IN*(SETTLE+1) cycles from the start edge to DONE entry. Defaults give 40.
- DONE (1 cycle):
  - done=1; pass=(err_count==0); stim<=0.
  - Next edge: busy<=0, go to IDLE.
- err_count width N_IN+1 holds the maximum of 2^N_IN errors with no wrap.
- Ignored inputs:
  - start while busy (SETTLE, SAMPLE, DONE) is ignored.
  - func_sel changes after acceptance are ignored.
- Start held high: a new run begins on the first IDLE edge after DONE. Result registers are cleared at that acceptance.
- Reset mid-run: run aborted and all outputs take reset values. The block stays in IDLE after release until a new start.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- func_sel=00, dut_out = ideal zero-delay 3-input AND of stim, start pulse -> done at cycle 40 after start, pass=1, err_count=0, first_fail_valid=0.
- func_sel=01, dut_out stuck at 0 -> err_count=7, first_fail_vec=3'b001, first_fail_valid=1, pass=0.
- func_sel=00, dut_out = AND through a 4-cycle register pipeline -> pass=1. Same with a 5-cycle pipeline -> err_count=1, first_fail_vec=3'b111, pass=0.
- func_sel=10 at start, then toggle func_sel=01 and pulse start at cycle 15 -> run unaffected; NAND checked, done at cycle 40, busy continuous.
- Mid-run rst_n=0 at cycle 20 -> stim, busy, err_count, etc. zero within the same cycle. No done after release until a new start; a new start completes normally in 40 cycles.
- start held high, dut_out stuck at 1 with func AND -> first run err_count=7, first_fail_vec=0. Second run starts the cycle after IDLE re-entry, err_count cleared to 0 at acceptance, then reaches 7 again.
